ram_dp_sync: RTL and testbench

RAM_DP_SYNC -- requirements
Module: ram_dp_sync

---
 rtl/ram_dp_sync_if.sv | 27 ++
 rtl/ram_dp_sync.sv | 107 ++++++++++
 tb/tb_ram_dp_sync.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_sync_if.sv
// Bus bundle for the simple dual-port RAM: write port, read port,
// clear request and the status outputs. The master drives requests,
// the slave (the RAM) returns read data, read-valid and busy.
interface ram_dp_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  clr_req;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/ram_dp_sync.sv
// Simple dual-port synchronous RAM with a registered, write-first read
// port and a self-timed clear sweep. Reset puts the controller into the
// sweep so the array is zeroed DEPTH cycles after reset release; while
// the sweep runs, user reads and writes are silently dropped.
module ram_dp_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_dp_sync_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Storage array; deliberately not reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Single memory write port, shared by user writes and the sweep.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Next-state, read-path and write-port selection.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;

        case (state_q)
            IDLE: begin
                if (bus.wr_en) begin
                    mem_we = 1'b1;
                end
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    // Same-address collision returns the word being written.
                    if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
                        rd_data_d = bus.wr_data;
                    end else begin
                        rd_data_d = mem[bus.rd_addr];
                    end
                end
                // A concurrent access still completes; sweep starts next edge.
                if (bus.clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                // clr_req, wr_en and rd_en are all ignored here.
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // Control and read-output registers; reset forces a fresh sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync (8-bit words, 16 deep). A behavioural model
// predicts busy and read results; predicted read data is queued when a
// read is driven and popped when the DUT raises rd_valid.
module tb_ram_dp_sync;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_dp_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    ram_dp_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t       vt [8];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mm [16];
    int         cnt;
    logic [7:0] last_data;
    logic [7:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; model updated with the values seen at the edge.
    task automatic step(input logic c, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic re, input logic [3:0] ra);
        logic       ev;
        logic [7:0] e;
        bus.clr_req = c;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        @(posedge clk);
        ev = 1'b0;
        if (!rst_n) begin
            cnt = 16;
            last_data = 8'h00;
            q.delete();
            for (int i = 0; i < 16; i++) mm[i] = 8'h00;
        end else if (cnt > 0) begin
            cnt--;
        end else begin
            if (we) mm[wa] = wd;
            if (re) begin
                q.push_back(mm[ra]);
                ev = 1'b1;
            end
            if (c) begin
                cnt = 16;
                for (int i = 0; i < 16; i++) mm[i] = 8'h00;
            end
        end
        #1;
        $display("t=%0t rst_n=%0b clr=%0b we=%0b wa=%0d wd=%02h re=%0b ra=%0d -> rd_valid=%0b rd_data=%02h busy=%0b",
                 $time, rst_n, c, we, wa, wd, re, ra, bus.rd_valid, bus.rd_data, bus.busy);
        chk("busy", 32'(bus.busy), 32'(cnt > 0));
        chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
        if (bus.rd_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got rd_valid=1 required no pending read");
            end else begin
                e = q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(e));
                last_data = e;
            end
        end else begin
            chk("rd_hold", 32'(bus.rd_data), 32'(last_data));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    endtask

    // Run while busy; optionally re-pulse clr_req and inject an access.
    task automatic sweep(input int pulse_at, input int inj_at, input string name);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == inj_at)
                step(1'b0, 1'b1, 4'd2, 8'h55, 1'b1, 4'd2);
            else
                step(n == pulse_at, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    task automatic fill(input logic [7:0] d);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), d, 1'b0, 4'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        last_data = 8'h00;
        q.delete();
        cnt = 16;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 4'd3,  8'hA5, 1'b1, 4'd3,  1'b1, 8'hA5};
        vt[1] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'hA5};
        vt[2] = '{1'b1, 4'd4,  8'h11, 1'b1, 4'd5,  1'b1, 8'h05};
        vt[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  1'b1, 8'h11};
        vt[4] = '{1'b1, 4'd0,  8'hC3, 1'b0, 4'd0,  1'b0, 8'h11};
        vt[5] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  1'b1, 8'hC3};
        vt[6] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h0F};
        vt[7] = '{1'b1, 4'd15, 8'h7E, 1'b1, 4'd15, 1'b1, 8'h7E};

        rst_n = 1'b0;
        cnt = 16;
        last_data = 8'h00;
        for (int i = 0; i < 16; i++) mm[i] = 8'h00;
        idle();
        idle();
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd1);

        // Power-up sweep, then everything reads as zero.
        rst_n = 1'b1;
        sweep(-1, -1, "sweep_power_up");
        read_all();

        // Address = data pattern.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 8'(i), 1'b0, 4'd0);
        read_all();

        // Directed table including the write-first collision.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra);
            chk("vec_valid", 32'(bus.rd_valid), 32'(vt[i].ev));
            chk("vec_data", 32'(bus.rd_data), 32'(vt[i].ed));
        end

        // Clear with a dropped write/read during the sweep.
        fill(8'hFF);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        sweep(-1, 1, "sweep_clr");
        read_all();

        // Reset in the middle of a sweep restarts it from address 0.
        fill(8'hAA);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        for (int k = 0; k < 7; k++) idle();
        async_reset_check();
        idle();
        idle();
        rst_n = 1'b1;
        sweep(-1, -1, "sweep_after_reset");
        read_all();

        // clr_req inside a sweep neither restarts nor extends it.
        fill(8'h3C);
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        sweep(4, -1, "sweep_repulse");

        // clr_req together with a write and read in IDLE.
        step(1'b0, 1'b1, 4'd9, 8'h99, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd7, 8'h77, 1'b1, 4'd9);
        sweep(-1, -1, "sweep_concurrent");
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);

        // Reset right after a read result clears rd_valid/rd_data at once.
        step(1'b0, 1'b1, 4'd1, 8'hE1, 1'b1, 4'd1);
        async_reset_check();
        idle();
        rst_n = 1'b1;
        sweep(-1, -1, "sweep_final");
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
